// File: rtl/core_pkg.sv
// Shared constants and entry layout for the complex reservation station,
// plus the operand wakeup function used by the slots and the dispatch bypass.
package core_pkg;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int ENTRY_W = 114;

    localparam int RD_LSB      = 0;
    localparam int RS1_RDY     = 5;
    localparam int RS1_LSB     = 6;
    localparam int RS2_RDY     = 38;
    localparam int RS2_LSB     = 39;
    localparam int REGWRITE    = 71;
    localparam int BRANCH      = 72;
    localparam int MEMTOREG    = 73;
    localparam int MEMREAD     = 74;
    localparam int MEMWRITE    = 75;
    localparam int ALUOP_LSB   = 76;
    localparam int MEMDATA_LSB = 82;

    typedef logic [ENTRY_W-1:0] rs_entry_t;

    // A not-ready operand holds its producer tag in its low TAG_W bits; cdb0 wins ties.
    function automatic rs_entry_t wakeup_entry(
        input rs_entry_t          e,
        input logic               c0_valid,
        input logic [TAG_W-1:0]   c0_tag,
        input logic [DATA_W-1:0]  c0_data,
        input logic               c1_valid,
        input logic [TAG_W-1:0]   c1_tag,
        input logic [DATA_W-1:0]  c1_data
    );
        rs_entry_t r;
        r = e;
        if (!e[RS1_RDY]) begin
            if (c0_valid && (c0_tag == e[RS1_LSB +: TAG_W])) begin
                r[RS1_LSB +: DATA_W] = c0_data;
                r[RS1_RDY]           = 1'b1;
            end else if (c1_valid && (c1_tag == e[RS1_LSB +: TAG_W])) begin
                r[RS1_LSB +: DATA_W] = c1_data;
                r[RS1_RDY]           = 1'b1;
            end
        end
        if (!e[RS2_RDY]) begin
            if (c0_valid && (c0_tag == e[RS2_LSB +: TAG_W])) begin
                r[RS2_LSB +: DATA_W] = c0_data;
                r[RS2_RDY]           = 1'b1;
            end else if (c1_valid && (c1_tag == e[RS2_LSB +: TAG_W])) begin
                r[RS2_LSB +: DATA_W] = c1_data;
                r[RS2_RDY]           = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_complex_slot.sv
// One reservation-station slot: stored entry, ROB number, valid bit and
// two-port CDB operand wakeup. Ready bits on the output are masked by valid.
module rs_complex_slot
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               i_write,
    input  rs_entry_t          i_entry,
    input  logic [TAG_W-1:0]   i_rob_num,
    input  logic               i_issue,
    input  logic               i_cdb0_valid,
    input  logic [TAG_W-1:0]   i_cdb0_tag,
    input  logic [DATA_W-1:0]  i_cdb0_data,
    input  logic               i_cdb1_valid,
    input  logic [TAG_W-1:0]   i_cdb1_tag,
    input  logic [DATA_W-1:0]  i_cdb1_data,
    output logic               o_valid,
    output rs_entry_t          o_entry,
    output logic [TAG_W-1:0]   o_entry_num
);

    logic             r_valid;
    rs_entry_t        r_entry;
    logic [TAG_W-1:0] r_entry_num;
    rs_entry_t        w_woken;

    assign w_woken = wakeup_entry(r_entry, i_cdb0_valid, i_cdb0_tag, i_cdb0_data,
                                  i_cdb1_valid, i_cdb1_tag, i_cdb1_data);

    // Writes only target a free slot, so write never collides with a real issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_entry     <= '0;
            r_entry_num <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_entry     <= '0;
            r_entry_num <= '0;
        end else if (i_write) begin
            r_valid     <= 1'b1;
            r_entry     <= i_entry;
            r_entry_num <= i_rob_num;
        end else if (r_valid) begin
            if (i_issue)
                r_valid <= 1'b0;
            else
                r_entry <= w_woken;
        end
    end

    always_comb begin
        o_entry          = r_entry;
        o_entry[RS1_RDY] = r_entry[RS1_RDY] & r_valid;
        o_entry[RS2_RDY] = r_entry[RS2_RDY] & r_valid;
    end

    assign o_valid     = r_valid;
    assign o_entry_num = r_entry_num;

endmodule

// File: rtl/rs_complex.sv
// Two-entry reservation station for the complex unit: slot allocation, age
// selector and dispatch bypass. Optional counters under RS_COMPLEX_PERF_EN.
module rs_complex
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               dispatch_valid,
    input  rs_entry_t          dispatch_entry,
    input  logic [TAG_W-1:0]   dispatch_rob_num,
    output logic               rs_ready,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_tag,
    input  logic [DATA_W-1:0]  cdb0_data,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_tag,
    input  logic [DATA_W-1:0]  cdb1_data,
    output rs_entry_t          rs_complex_0,
    output rs_entry_t          rs_complex_1,
    output logic [TAG_W-1:0]   rs_complex_0_entry_num,
    output logic [TAG_W-1:0]   rs_complex_1_entry_num,
    output logic               selector,
    input  logic               complex_0_issue,
    input  logic               complex_1_issue
`ifdef RS_COMPLEX_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_issue_cnt
`endif
);

    logic [1:0]       w_valid;
    logic [1:0]       w_write;
    logic [1:0]       w_issue;
    logic [1:0]       w_remain;
    logic             w_accept;
    logic             w_selector_next;
    logic             r_selector;
    rs_entry_t        w_bypass;
    rs_entry_t        w_slot_entry [2];
    logic [TAG_W-1:0] w_slot_num   [2];

    assign rs_ready = ~(w_valid[0] & w_valid[1]);
    assign w_accept = dispatch_valid & rs_ready;
    assign w_write  = {w_accept & w_valid[0], w_accept & ~w_valid[0]};
    assign w_issue  = {complex_1_issue, complex_0_issue};
    assign w_remain = w_valid & ~w_issue;

    // Catch a broadcast landing in the same cycle as the dispatch.
    assign w_bypass = wakeup_entry(dispatch_entry, cdb0_valid, cdb0_tag, cdb0_data,
                                   cdb1_valid, cdb1_tag, cdb1_data);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            rs_complex_slot u_slot (
                .clk          (clk),
                .rst_n        (rst_n),
                .flush        (flush),
                .i_write      (w_write[gi]),
                .i_entry      (w_bypass),
                .i_rob_num    (dispatch_rob_num),
                .i_issue      (w_issue[gi]),
                .i_cdb0_valid (cdb0_valid),
                .i_cdb0_tag   (cdb0_tag),
                .i_cdb0_data  (cdb0_data),
                .i_cdb1_valid (cdb1_valid),
                .i_cdb1_tag   (cdb1_tag),
                .i_cdb1_data  (cdb1_data),
                .o_valid      (w_valid[gi]),
                .o_entry      (w_slot_entry[gi]),
                .o_entry_num  (w_slot_num[gi])
            );
        end
    endgenerate

    assign rs_complex_0           = w_slot_entry[0];
    assign rs_complex_1           = w_slot_entry[1];
    assign rs_complex_0_entry_num = w_slot_num[0];
    assign rs_complex_1_entry_num = w_slot_num[1];

    // A fresh dispatch is always the newest; otherwise follow the sole survivor.
    always_comb begin
        w_selector_next = r_selector;
        if (w_write[0])
            w_selector_next = 1'b0;
        else if (w_write[1])
            w_selector_next = 1'b1;
        else if (w_remain == 2'b01)
            w_selector_next = 1'b0;
        else if (w_remain == 2'b10)
            w_selector_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_selector <= 1'b0;
        else if (flush)
            r_selector <= 1'b0;
        else
            r_selector <= w_selector_next;
    end

    assign selector = r_selector;

`ifdef RS_COMPLEX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_issue_cnt;
    logic [31:0] w_issue_inc;

    assign w_issue_inc = {31'd0, w_valid[0] & w_issue[0]} + {31'd0, w_valid[1] & w_issue[1]};

    // Counters survive flush; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (dispatch_valid && !rs_ready)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            r_issue_cnt <= r_issue_cnt + w_issue_inc;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_rs_complex.sv
// Table-driven bench for rs_complex: per-cycle stimulus rows with hand-computed
// expected slot contents, plus hand sequences for async reset mid-dispatch.
module tb_rs_complex;
    import core_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             dispatch_valid;
    rs_entry_t        dispatch_entry;
    logic [TAG_W-1:0] dispatch_rob_num;
    logic             rs_ready;
    logic             cdb0_valid, cdb1_valid;
    logic [TAG_W-1:0] cdb0_tag, cdb1_tag;
    logic [DATA_W-1:0] cdb0_data, cdb1_data;
    rs_entry_t        rs_complex_0, rs_complex_1;
    logic [TAG_W-1:0] rs_complex_0_entry_num, rs_complex_1_entry_num;
    logic             selector;
    logic             complex_0_issue, complex_1_issue;
`ifdef RS_COMPLEX_PERF_EN
    logic [31:0]      perf_stall_cnt, perf_issue_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rs_complex dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .flush                  (flush),
        .dispatch_valid         (dispatch_valid),
        .dispatch_entry         (dispatch_entry),
        .dispatch_rob_num       (dispatch_rob_num),
        .rs_ready               (rs_ready),
        .cdb0_valid             (cdb0_valid),
        .cdb0_tag               (cdb0_tag),
        .cdb0_data              (cdb0_data),
        .cdb1_valid             (cdb1_valid),
        .cdb1_tag               (cdb1_tag),
        .cdb1_data              (cdb1_data),
        .rs_complex_0           (rs_complex_0),
        .rs_complex_1           (rs_complex_1),
        .rs_complex_0_entry_num (rs_complex_0_entry_num),
        .rs_complex_1_entry_num (rs_complex_1_entry_num),
        .selector               (selector),
        .complex_0_issue        (complex_0_issue),
        .complex_1_issue        (complex_1_issue)
`ifdef RS_COMPLEX_PERF_EN
        ,
        .perf_stall_cnt         (perf_stall_cnt),
        .perf_issue_cnt         (perf_issue_cnt)
`endif
    );

    typedef struct {
        logic             dv;
        rs_entry_t        e;
        logic [3:0]       rob;
        logic             i0, i1, fl;
        logic             c0v;
        logic [3:0]       c0t;
        logic [31:0]      c0d;
        logic             c1v;
        logic [3:0]       c1t;
        logic [31:0]      c1d;
        logic             x_rdy, x_sel;
        rs_entry_t        x_e0, x_e1;
        logic [3:0]       x_n0, x_n1;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic rs_entry_t mk(input logic [4:0] rd, input logic r1rdy, input logic [31:0] r1,
                                     input logic r2rdy, input logic [31:0] r2,
                                     input logic [10:0] ctl, input logic [31:0] mem);
        return {mem, ctl, r2, r2rdy, r1, r1rdy, rd};
    endfunction

    function automatic rs_entry_t msk(input rs_entry_t e);
        rs_entry_t r;
        r = e;
        r[5]  = 1'b0;
        r[38] = 1'b0;
        return r;
    endfunction

    function automatic vec_t row(input logic dv, input rs_entry_t e, input logic [3:0] rob,
                                 input logic i0, input logic i1, input logic fl,
                                 input logic rdy, input logic sel, input rs_entry_t e0,
                                 input rs_entry_t e1, input logic [3:0] n0, input logic [3:0] n1);
        vec_t v;
        v.dv = dv; v.e = e; v.rob = rob; v.i0 = i0; v.i1 = i1; v.fl = fl;
        v.c0v = 1'b0; v.c0t = '0; v.c0d = '0;
        v.c1v = 1'b0; v.c1t = '0; v.c1d = '0;
        v.x_rdy = rdy; v.x_sel = sel; v.x_e0 = e0; v.x_e1 = e1; v.x_n0 = n0; v.x_n1 = n1;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [ENTRY_W-1:0] act,
                       input logic [ENTRY_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0; dispatch_valid = 1'b0; dispatch_entry = '0; dispatch_rob_num = '0;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
        complex_0_issue = 1'b0; complex_1_issue = 1'b0;
    endtask

    rs_entry_t A, B, C, C1, D, D1, D2, E, E1, F, G, H, Z;

    initial begin
        A  = mk(5'd1, 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 11'h0A1, 32'hA0A0_A0A0);
        B  = mk(5'd2, 1'b1, 32'h3333_3333, 1'b1, 32'h4444_4444, 11'h155, 32'hB0B0_B0B0);
        C  = mk(5'd3, 1'b0, 32'h0000_0005, 1'b1, 32'h5555_5555, 11'h002, 32'h0);
        C1 = mk(5'd3, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h5555_5555, 11'h002, 32'h0);
        D  = mk(5'd4, 1'b0, 32'h0000_0005, 1'b0, 32'h0000_0007, 11'h7FF, 32'h1234);
        D1 = mk(5'd4, 1'b1, 32'hAAAA_0000, 1'b0, 32'h0000_0007, 11'h7FF, 32'h1234);
        D2 = mk(5'd4, 1'b1, 32'hAAAA_0000, 1'b1, 32'h0000_0012, 11'h7FF, 32'h1234);
        E  = mk(5'd5, 1'b1, 32'h0000_0066, 1'b0, 32'h0000_0007, 11'h040, 32'h0);
        E1 = mk(5'd5, 1'b1, 32'h0000_0066, 1'b1, 32'h0000_0012, 11'h040, 32'h0);
        F  = mk(5'd6, 1'b1, 32'h0000_0077, 1'b1, 32'h0000_0088, 11'h100, 32'h0);
        G  = mk(5'd7, 1'b1, 32'h0000_0099, 1'b1, 32'h0000_00AA, 11'h003, 32'hFFFF_FFFF);
        H  = mk(5'd8, 1'b0, 32'h0000_0003, 1'b1, 32'h0000_00BB, 11'h000, 32'h0);
        Z  = '0;

        //             dv  entry rob i0 i1 fl  rdy sel  e0       e1       n0 n1
        vecs[0]  = row(0,  Z,  0,  0, 0, 0,  1,  0,  Z,       Z,       0, 0);
        vecs[1]  = row(1,  A,  3,  0, 0, 0,  1,  0,  A,       Z,       3, 0);
        vecs[2]  = row(1,  B,  4,  0, 0, 0,  0,  1,  A,       B,       3, 4);
        vecs[3]  = row(0,  Z,  0,  1, 0, 0,  1,  1,  msk(A),  B,       3, 4);
        vecs[4]  = row(1,  C,  6,  0, 0, 0,  0,  0,  C,       B,       6, 4);
        vecs[5]  = row(0,  Z,  0,  0, 0, 0,  0,  0,  C1,      B,       6, 4);
        vecs[5].c1v = 1; vecs[5].c1t = 4'd5; vecs[5].c1d = 32'hDEAD_BEEF;
        vecs[6]  = row(0,  Z,  0,  1, 1, 0,  1,  0,  msk(C1), msk(B),  6, 4);
        vecs[7]  = row(1,  D,  8,  0, 0, 0,  1,  0,  D,       msk(B),  8, 4);
        vecs[8]  = row(0,  Z,  0,  0, 0, 0,  1,  0,  D1,      msk(B),  8, 4);
        vecs[8].c0v = 1; vecs[8].c0t = 4'd5; vecs[8].c0d = 32'hAAAA_0000;
        vecs[8].c1v = 1; vecs[8].c1t = 4'd5; vecs[8].c1d = 32'hBBBB_0000;
        vecs[9]  = row(1,  E,  9,  0, 0, 0,  0,  1,  D2,      E1,      8, 9);
        vecs[9].c0v = 1; vecs[9].c0t = 4'd7; vecs[9].c0d = 32'h0000_0012;
        vecs[10] = row(1,  F, 10,  1, 0, 0,  1,  1,  msk(D2), E1,      8, 9);
        vecs[11] = row(1,  F, 10,  0, 0, 0,  0,  0,  F,       E1,     10, 9);
        vecs[12] = row(0,  Z,  0,  0, 1, 0,  1,  0,  F,       msk(E1),10, 9);
        vecs[13] = row(1,  G, 11,  1, 0, 0,  1,  1,  msk(F),  G,      10, 11);
        vecs[14] = row(0,  Z,  0,  1, 0, 0,  1,  1,  msk(F),  G,      10, 11);
        vecs[15] = row(1,  H, 12,  0, 0, 0,  0,  0,  H,       G,      12, 11);
        vecs[16] = row(1,  A,  3,  0, 0, 1,  1,  0,  Z,       Z,       0, 0);
        vecs[16].c0v = 1; vecs[16].c0t = 4'd3; vecs[16].c0d = 32'h0000_0099;
        vecs[17] = row(1,  A,  3,  0, 0, 0,  1,  0,  A,       Z,       3, 0);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset asserted mid-cycle while a dispatch is in flight.
        dispatch_valid = 1'b1; dispatch_entry = A; dispatch_rob_num = 4'd3;
        @(posedge clk); #1;
        chk("pre_reset_slot0", -1, rs_complex_0, A);
        dispatch_entry = B; dispatch_rob_num = 4'd4;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", -1, {113'd0, rs_ready}, {113'd0, 1'b1});
        chk("rst_sel", -1, {113'd0, selector}, '0);
        chk("rst_rdy_bits0", -1, {112'd0, rs_complex_0[38], rs_complex_0[5]}, '0);
        chk("rst_rdy_bits1", -1, {112'd0, rs_complex_1[38], rs_complex_1[5]}, '0);
        chk("rst_slot0", -1, rs_complex_0, '0);
        dispatch_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            dispatch_valid = vecs[i].dv; dispatch_entry = vecs[i].e; dispatch_rob_num = vecs[i].rob;
            complex_0_issue = vecs[i].i0; complex_1_issue = vecs[i].i1; flush = vecs[i].fl;
            cdb0_valid = vecs[i].c0v; cdb0_tag = vecs[i].c0t; cdb0_data = vecs[i].c0d;
            cdb1_valid = vecs[i].c1v; cdb1_tag = vecs[i].c1t; cdb1_data = vecs[i].c1d;
            @(posedge clk); #1;
            chk("rs_ready", i, {113'd0, rs_ready}, {113'd0, vecs[i].x_rdy});
            chk("selector", i, {113'd0, selector}, {113'd0, vecs[i].x_sel});
            chk("slot0", i, rs_complex_0, vecs[i].x_e0);
            chk("slot1", i, rs_complex_1, vecs[i].x_e1);
            chk("num0", i, {110'd0, rs_complex_0_entry_num}, {110'd0, vecs[i].x_n0});
            chk("num1", i, {110'd0, rs_complex_1_entry_num}, {110'd0, vecs[i].x_n1});
        end
        idle_inputs();

`ifdef RS_COMPLEX_PERF_EN
        chk("perf_stall", NV, {82'd0, perf_stall_cnt}, {82'd0, 32'd2});
        chk("perf_issue", NV, {82'd0, perf_issue_cnt}, {82'd0, 32'd6});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
